// File: rtl/aes_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module  : aes_ctrl_pkg
// Brief   : Shared types and constants for the AES core arbiter slice.
// Revision: 1.0 - initial release
// ============================================================================
package aes_ctrl_pkg;

    // Key and text blocks are always one full AES block wide.
    localparam int AES_BLK_W = 128;

    // Controller state; IDLE must stay at zero so busy is simply state != IDLE.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_WAIT = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    // Index width for n requesters, never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/aes_core_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module  : aes_core_arbiter_if
// Brief   : Requester-side and cipher-side buses of the AES core arbiter.
// Revision: 1.0 - initial release
// ============================================================================
interface aes_core_arbiter_if
    import aes_ctrl_pkg::*;
#(
    parameter int NUM_REQ = 4
);
    // Requester request channel
    logic [NUM_REQ-1:0]           req_valid;
    logic [NUM_REQ*AES_BLK_W-1:0] req_key;
    logic [NUM_REQ*AES_BLK_W-1:0] req_text;
    logic [NUM_REQ-1:0]           req_ready;
    // Requester response channel
    logic [NUM_REQ-1:0]           rsp_valid;
    logic [NUM_REQ-1:0]           rsp_ready;
    logic [AES_BLK_W-1:0]         rsp_data;
    logic                         rsp_err;
    // Shared cipher core
    logic                         core_ld;
    logic [AES_BLK_W-1:0]         core_key;
    logic [AES_BLK_W-1:0]         core_text;
    logic                         core_done;
    logic [AES_BLK_W-1:0]         core_text_out;

    // Arbiter side
    modport slave (
        input  req_valid, req_key, req_text, rsp_ready, core_done, core_text_out,
        output req_ready, rsp_valid, rsp_data, rsp_err, core_ld, core_key, core_text
    );

    // Requesters plus cipher side
    modport master (
        output req_valid, req_key, req_text, rsp_ready, core_done, core_text_out,
        input  req_ready, rsp_valid, rsp_data, rsp_err, core_ld, core_key, core_text
    );
endinterface
`default_nettype wire

// File: rtl/aes_core_arbiter_rr.sv
`default_nettype none
// ============================================================================
// Module  : aes_rr_arbiter
// Brief   : Combinational round-robin pick, searching upward from ptr+1.
// Revision: 1.0 - initial release
// ============================================================================
module aes_rr_arbiter
    import aes_ctrl_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = idx_w(NUM_REQ)
) (
    input  wire logic [NUM_REQ-1:0] req,
    input  wire logic [IDX_W-1:0]   ptr,
    output logic      [NUM_REQ-1:0] grant,
    output logic      [IDX_W-1:0]   grant_idx,
    output logic                    any_req
);
    int               w_pos;
    logic [IDX_W-1:0] w_sel;
    logic             w_found;

    // Walk the requesters once starting after the last owner; first hit wins.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        w_found   = 1'b0;
        w_pos     = 0;
        w_sel     = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_pos = (int'(ptr) + k) % NUM_REQ;
            w_sel = IDX_W'(w_pos);
            if (!w_found && req[w_sel]) begin
                grant[w_sel] = 1'b1;
                grant_idx    = w_sel;
                w_found      = 1'b1;
            end
        end
    end

    assign any_req = |req;

endmodule
`default_nettype wire

// File: rtl/aes_core_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : aes_core_arbiter
// Brief   : Shares one AES cipher core between NUM_REQ full-block requesters
//           with round-robin grant, one-shot load and a completion watchdog.
// Revision: 1.0 - initial release
// ============================================================================
module aes_core_arbiter
    import aes_ctrl_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  wire logic                      clk,
    input  wire logic                      rst,      // asynchronous, active low
    aes_core_arbiter_if.slave              bus,
    output logic                           busy,
    output logic [idx_w(NUM_REQ)-1:0]      grant_id
);
    localparam int                 c_IDX_W    = idx_w(NUM_REQ);
    localparam int                 c_CNT_W    = $clog2(TIMEOUT_CYCLES);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT_CYCLES - 1);

    state_t               r_state;
    state_t               w_next;
    logic [c_IDX_W-1:0]   r_rr_ptr;
    logic [c_IDX_W-1:0]   r_grant_id;
    logic [AES_BLK_W-1:0] r_core_key;
    logic [AES_BLK_W-1:0] r_core_text;
    logic [AES_BLK_W-1:0] r_rsp_data;
    logic                 r_rsp_err;
    logic [NUM_REQ-1:0]   r_rsp_valid;
    logic [c_CNT_W-1:0]   r_cnt;

    logic [NUM_REQ-1:0]   w_grant;
    logic [c_IDX_W-1:0]   w_grant_idx;
    logic                 w_any_req;
    logic [NUM_REQ-1:0]   w_owner;
    logic                 w_accept;
    logic                 w_expired;

    aes_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (c_IDX_W)
    ) u_rr (
        .req       (bus.req_valid),
        .ptr       (r_rr_ptr),
        .grant     (w_grant),
        .grant_idx (w_grant_idx),
        .any_req   (w_any_req)
    );

    assign w_owner   = NUM_REQ'(1) << r_grant_id;
    assign w_accept  = bus.rsp_ready[r_grant_id];
    assign w_expired = (r_cnt == c_CNT_LAST);

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= ST_IDLE;
        else      r_state <= w_next;
    end

    // Next-state and decoded outputs; req_ready is masked while reset is held
    // so a pending request cannot show an acceptance during reset.
    always_comb begin
        w_next        = r_state;
        bus.req_ready = '0;
        bus.core_ld   = 1'b0;
        busy          = (r_state != ST_IDLE);
        case (r_state)
            ST_IDLE: begin
                if (rst) bus.req_ready = w_grant;
                if (w_any_req) w_next = ST_LOAD;
            end
            ST_LOAD: begin
                bus.core_ld = 1'b1;
                w_next      = ST_WAIT;
            end
            ST_WAIT: if (bus.core_done || w_expired) w_next = ST_RESP;
            ST_RESP: if (w_accept) w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    // Capture, watchdog and response registers; done has priority over expiry.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rr_ptr    <= c_IDX_W'(NUM_REQ - 1);
            r_grant_id  <= '0;
            r_core_key  <= '0;
            r_core_text <= '0;
            r_rsp_data  <= '0;
            r_rsp_err   <= 1'b0;
            r_rsp_valid <= '0;
            r_cnt       <= '0;
        end else begin
            case (r_state)
                ST_IDLE: if (w_any_req) begin
                    r_core_key  <= bus.req_key[int'(w_grant_idx)*AES_BLK_W +: AES_BLK_W];
                    r_core_text <= bus.req_text[int'(w_grant_idx)*AES_BLK_W +: AES_BLK_W];
                    r_grant_id  <= w_grant_idx;
                    r_rr_ptr    <= w_grant_idx;
                end
                ST_LOAD: r_cnt <= '0;
                ST_WAIT: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (bus.core_done) begin
                        r_rsp_data  <= bus.core_text_out;
                        r_rsp_err   <= 1'b0;
                        r_rsp_valid <= w_owner;
                    end else if (w_expired) begin
                        r_rsp_data  <= '0;
                        r_rsp_err   <= 1'b1;
                        r_rsp_valid <= w_owner;
                    end
                end
                ST_RESP: if (w_accept) r_rsp_valid <= '0;
                default: ;
            endcase
        end
    end

    assign bus.core_key  = r_core_key;
    assign bus.core_text = r_core_text;
    assign bus.rsp_data  = r_rsp_data;
    assign bus.rsp_err   = r_rsp_err;
    assign bus.rsp_valid = r_rsp_valid;
    assign grant_id      = r_grant_id;

endmodule
`default_nettype wire

// File: tb/tb_aes_core_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_aes_core_arbiter
// Brief   : Self-checking bench for aes_core_arbiter with a behavioural core.
// Revision: 1.0 - initial release
// ============================================================================
module tb_aes_core_arbiter;
    import aes_ctrl_pkg::*;

    localparam int N   = 4;
    localparam int TMO = 64;
    localparam logic [127:0] FIPS_K = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] FIPS_T = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] FIPS_C = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic       clk;
    logic       rst;
    logic       busy;
    logic [1:0] grant_id;

    aes_core_arbiter_if #(.NUM_REQ(N)) ifc ();

    aes_core_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(TMO)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (ifc.slave),
        .busy     (busy),
        .grant_id (grant_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int m_last   = N - 1;          // reference model: last granted requester
    logic [127:0] key_a  [N];
    logic [127:0] text_a [N];

    typedef struct {
        logic [3:0] mask;
        int         lat;     // 0 = core never completes
        int         exp_id;
        int         rdly;    // cycles rsp_ready is held low by the owner
        bit         hold;    // keep req_valid asserted after the grant
    } vec_t;
    vec_t tbl[11];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Behavioural cipher: real AES answer for the FIPS-197 block, otherwise
    // an arbitrary reversible mix that still identifies key and text.
    function automatic logic [127:0] cipher(input logic [127:0] k, input logic [127:0] t);
        if (k == FIPS_K && t == FIPS_T) return FIPS_C;
        return (k ^ {t[63:0], t[127:64]}) + 128'h1234_5678;
    endfunction

    function automatic int model_pick(input logic [3:0] mask);
        for (int s = 1; s <= N; s++) begin
            int i;
            i = (m_last + s) % N;
            if (mask[i]) return i;
        end
        return -1;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic load_blocks();
        for (int i = 0; i < N; i++) begin
            ifc.req_key[i*128 +: 128]  = key_a[i];
            ifc.req_text[i*128 +: 128] = text_a[i];
        end
    endtask

    // One complete transaction, entered and left at negedge+1 with the DUT idle.
    task automatic do_txn(input logic [3:0] mask, input int lat, input int exp_id,
                          input int rdly, input bit hold);
        bit           got;
        bit           ok_end;
        int           resp_k;
        logic [127:0] exp_data;
        logic         exp_err;
        ok_end   = (lat >= 1 && lat <= TMO);
        resp_k   = ok_end ? lat + 1 : TMO + 1;
        exp_data = ok_end ? cipher(key_a[exp_id], text_a[exp_id]) : '0;
        exp_err  = !ok_end;
        ifc.req_valid = mask;
        ifc.rsp_ready = '1;
        got = 0;
        for (int w = 0; w < 8; w++) begin
            #1;
            if (ifc.req_ready != 0) begin
                got = 1;
                break;
            end
            @(negedge clk);
        end
        if (!got) begin
            chk("grant_wait_expired", 0, 1);
            return;
        end
        chk("req_ready", ifc.req_ready, 4'b1 << exp_id);
        m_last = exp_id;
        // LOAD cycle
        @(negedge clk);
        if (!hold) ifc.req_valid = '0;
        #1;
        chk("core_ld", ifc.core_ld, 1);
        chk("core_key", ifc.core_key, key_a[exp_id]);
        chk("core_text", ifc.core_text, text_a[exp_id]);
        chk("busy_load", busy, 1);
        chk("grant_id_load", grant_id, exp_id);
        // WAIT cycles, core model pulses done after lat cycles
        for (int k = 1; k < resp_k; k++) begin
            @(negedge clk);
            ifc.core_done     = (k == lat);
            ifc.core_text_out = (k == lat) ? cipher(key_a[exp_id], text_a[exp_id]) : rnd128();
            #1;
            chk("core_ld_single", ifc.core_ld, 0);
            chk("rsp_early", ifc.rsp_valid, 0);
            chk("req_ready_busy", ifc.req_ready, 0);
        end
        // First RESP cycle
        @(negedge clk);
        ifc.core_done = 1'b0;
        if (rdly > 0) ifc.rsp_ready = ~(4'b1 << exp_id);
        #1;
        chk("rsp_valid", ifc.rsp_valid, 4'b1 << exp_id);
        chk("rsp_data", ifc.rsp_data, exp_data);
        chk("rsp_err", ifc.rsp_err, exp_err);
        chk("grant_id_rsp", grant_id, exp_id);
        // Backpressure with a stray core_done that must be ignored
        for (int d = 1; d <= rdly; d++) begin
            @(negedge clk);
            ifc.core_done     = (d == 5);
            ifc.core_text_out = rnd128();
            if (d == rdly) ifc.rsp_ready = '1;
            #1;
            chk("rsp_valid_hold", ifc.rsp_valid, 4'b1 << exp_id);
            chk("rsp_data_hold", ifc.rsp_data, exp_data);
            chk("rsp_err_hold", ifc.rsp_err, exp_err);
            chk("req_ready_resp", ifc.req_ready, 0);
        end
        // Accepted: IDLE next cycle
        @(negedge clk);
        ifc.core_done = 1'b0;
        #1;
        chk("busy_after", busy, 0);
        chk("rsp_valid_clr", ifc.rsp_valid, 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog_timeout actual=hung required=finish");
        $fatal(1);
    end

    initial begin
        tbl[0]  = '{4'b1111, 12, 0, 0,  1'b1};   // FIPS-197 vector
        tbl[1]  = '{4'b1111, 5,  1, 20, 1'b1};   // backpressure
        tbl[2]  = '{4'b1111, 64, 2, 0,  1'b1};   // done on final counter cycle
        tbl[3]  = '{4'b1111, 0,  3, 8,  1'b1};   // timeout + late done
        tbl[4]  = '{4'b1111, 3,  0, 0,  1'b0};   // wrap back to 0
        tbl[5]  = '{4'b0100, 1,  2, 0,  1'b0};
        tbl[6]  = '{4'b1001, 7,  3, 0,  1'b0};
        tbl[7]  = '{4'b1001, 2,  0, 1,  1'b0};
        tbl[8]  = '{4'b0010, 9,  1, 0,  1'b0};
        tbl[9]  = '{4'b1000, 4,  3, 2,  1'b0};
        tbl[10] = '{4'b0110, 6,  1, 0,  1'b0};

        key_a[0] = FIPS_K;  text_a[0] = FIPS_T;
        key_a[1] = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
        text_a[1] = 128'hdead_beef_0000_1111_2222_3333_4444_5555;
        key_a[2] = 128'hcafe_f00d_0123_4567_89ab_cdef_fedc_ba98;
        text_a[2] = 128'h0f0e_0d0c_0b0a_0908_0706_0504_0302_0100;
        key_a[3] = 128'ha5a5_5a5a_c3c3_3c3c_9696_6969_f0f0_0f0f;
        text_a[3] = 128'h0123_4567_89ab_cdef_0011_2233_4455_6677;

        rst = 1'b0;
        ifc.req_valid = 4'b1111;
        ifc.rsp_ready = '1;
        ifc.core_done = 1'b0;
        ifc.core_text_out = '0;
        load_blocks();
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("rst_req_ready", ifc.req_ready, 0);
        chk("rst_rsp_valid", ifc.rsp_valid, 0);
        chk("rst_rsp_data", ifc.rsp_data, 0);
        chk("rst_rsp_err", ifc.rsp_err, 0);
        chk("rst_core_ld", ifc.core_ld, 0);
        chk("rst_core_key", ifc.core_key, 0);
        chk("rst_core_text", ifc.core_text, 0);
        chk("rst_busy", busy, 0);
        chk("rst_grant_id", grant_id, 0);
        @(negedge clk);
        rst = 1'b1;

        for (int v = 0; v < 11; v++)
            do_txn(tbl[v].mask, tbl[v].lat, tbl[v].exp_id, tbl[v].rdly, tbl[v].hold);

        // Spurious done while idle
        ifc.req_valid = '0;
        @(negedge clk);
        ifc.core_done = 1'b1;
        ifc.core_text_out = rnd128();
        @(negedge clk);
        ifc.core_done = 1'b0;
        #1;
        chk("spurious_busy", busy, 0);
        chk("spurious_rsp", ifc.rsp_valid, 0);

        // Reset six cycles after core_ld
        ifc.req_valid = 4'b0010;
        #1;
        chk("mr_grant", ifc.req_ready, 4'b1 << model_pick(4'b0010));
        @(negedge clk);
        ifc.req_valid = 4'b1111;
        #1;
        chk("mr_core_ld", ifc.core_ld, 1);
        for (int k = 1; k <= 6; k++) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("mr_req_ready", ifc.req_ready, 0);
        chk("mr_rsp_valid", ifc.rsp_valid, 0);
        chk("mr_core_ld_0", ifc.core_ld, 0);
        chk("mr_core_key", ifc.core_key, 0);
        chk("mr_core_text", ifc.core_text, 0);
        chk("mr_busy", busy, 0);
        chk("mr_grant_id", grant_id, 0);
        @(negedge clk);
        rst = 1'b1;
        ifc.req_valid = '0;
        m_last = N - 1;
        @(negedge clk);
        ifc.core_done = 1'b1;
        ifc.core_text_out = rnd128();
        @(negedge clk);
        ifc.core_done = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("mr_late_done_rsp", ifc.rsp_valid, 0);
            chk("mr_late_done_busy", busy, 0);
            @(negedge clk);
        end
        do_txn(4'b0101, 10, model_pick(4'b0101), 0, 1'b0);   // ptr restored: 0 first
        do_txn(4'b0100, 8, model_pick(4'b0100), 1, 1'b0);

        // Randomised traffic against the transaction-level model
        for (int t = 0; t < 25; t++) begin
            logic [3:0] mask;
            int         lat;
            int         sel;
            for (int i = 0; i < N; i++) begin
                key_a[i]  = rnd128();
                text_a[i] = rnd128();
            end
            load_blocks();
            mask = 4'($urandom_range(1, 15));
            sel  = $urandom_range(0, 9);
            lat  = (sel == 0) ? 0 : (sel == 1) ? TMO : $urandom_range(1, 30);
            do_txn(mask, lat, model_pick(mask), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
